dlatch_bank: RTL
================

Name: dlatch_bank

Overview:
- Parametrised, clocked successor to the single-bit enable latch (ports d, en, rstn, q).
- Holds CHANNELS independent WIDTH-bit storage channels, each with its own enable and synchronous clear.
- A global mode selects one capture policy for all channels: level-transparent, edge capture, capture-and-hold (glitch-filter window) or freeze.
- Sits between asynchronous-ish control/data sources and downstream logic that needs stable, flagged sampled values.

Parameters:
- WIDTH, 1, data bits per channel (>=1)
- CHANNELS, 4, number of independent channels (>=1)
- HOLD_CYCLES, 4, cycles a channel ignores en after a HOLD-mode capture (>=1)
- RESET_VAL, 0, WIDTH-bit value loaded into every channel on reset or clear

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rstn  input  1  reset, asynchronous, active-low
- mode  input  2  global capture mode: 00 LEVEL, 01 EDGE, 10 HOLD, 11 FREEZE
- d  input  CHANNELS*WIDTH  channel data; channel c occupies bits [c*WIDTH +: WIDTH]
- en  input  CHANNELS  per-channel enable
- clr  input  CHANNELS  per-channel synchronous clear
- q  output  CHANNELS*WIDTH  stored channel values, same packing as d
- cap  output  CHANNELS  one-cycle pulse, high in the cycle q[c] shows a newly captured value
- busy  output  CHANNELS  high while channel is in its HOLD window

Behaviour:
- Reset (rstn=0, asynchronous): all q channels = RESET_VAL, cap=0, busy=0, state=IDLE, hold counters=0, en_prev=0.
- Per channel, evaluated every rising clk edge:
  - en_rise = en[c] & ~en_prev[c]; en_prev[c] <= en[c] every cycle in every mode.
  - Because en_prev resets to 0, en held high across reset release produces a rise on the first active edge.
- Priority: clr > capture > hold.
  - clr[c]=1: q[c] <= RESET_VAL, state <= IDLE, counter <= 0, cap[c] <= 0, busy[c] <= 0.
- LEVEL: if en[c]=1, q[c] <= d[c], cap[c] <= 1. q is registered (1-cycle latency, no combinational path d->q).
- EDGE: if en_rise, q[c] <= d[c], cap[c] <= 1; en held high captures only once.
- HOLD, channel FSM states IDLE and HOLD:
  - IDLE, en_rise: q[c] <= d[c], cap[c] <= 1, counter <= HOLD_CYCLES, state <= HOLD.
  - In HOLD, en and d are ignored, busy[c]=1, and the counter decrements each cycle.
  - When the counter decrements from 1 to 0, state <= IDLE in that same edge. busy is therefore high for exactly HOLD_CYCLES cycles, starting the cycle after capture.
  - A rise on the exact edge that leaves HOLD is ignored. The next capture needs a fresh en_rise detected in IDLE.
- FREEZE: no captures. q holds and cap=0. clr is still honoured.
- Mode change: takes effect on the next edge. Any channel in HOLD when mode != HOLD returns to IDLE (counter 0, busy 0) on that edge, with no capture that edge.
- cap is registered and is a pulse only: it returns to 0 the cycle after, unless another capture occurs (LEVEL with en held high keeps cap=1).
- cap asserts on capture even when the captured value equals the old q.
- Counter width is $clog2(HOLD_CYCLES+1). No wrap is possible.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

Decomposition:
- Package dlatch_pkg:
  - mode encoding constants or enum: MODE_LEVEL, MODE_EDGE, MODE_HOLD, MODE_FREEZE.
  - channel state enum: ST_IDLE, ST_HOLD.
- Sub-module dlatch_chan implements one channel: en_prev, FSM, counter, q/cap/busy.
- dlatch_bank instantiates CHANNELS copies in a generate loop and slices d/q.

Test Plan:
- Reset/LEVEL: WIDTH=1, CHANNELS=4, rstn low for 2 cycles, then release with mode=00, en=0000, d=1111 -> q=0000, cap=0000. Set en=0101 -> next cycle q=0101, cap=0101; drop en -> q holds, cap=0000.
- EDGE: mode=01, en[0] held high 5 cycles while d[0] toggles every cycle -> exactly one capture (first cycle value); cap[0] is high for 1 cycle only.
- HOLD: HOLD_CYCLES=4, mode=10, en[1] rises with d[1]=1, then d[1]=0 and en[1] toggles -> q[1]=1 persists and busy[1] is high for exactly 4 cycles. A rise after busy drops captures the new d.
- clr priority: en[2] rise and clr[2] in the same cycle during HOLD mode -> q[2]=RESET_VAL, cap[2]=0, busy[2]=0, state IDLE.
- Mode abort and FREEZE: enter HOLD on ch3, switch mode to 11 mid-window -> busy[3]=0 next cycle. en pulses in FREEZE leave q unchanged; clr still clears.
- Async reset mid-operation: assert rstn=0 between clock edges while busy=1111 -> q, cap and busy go to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/dlatch_pkg.sv
// Shared definitions for the dlatch_bank channel array: capture modes and
// per-channel FSM states.
package dlatch_pkg;

   typedef enum logic [1:0] {
      MODE_LEVEL  = 2'b00,
      MODE_EDGE   = 2'b01,
      MODE_HOLD   = 2'b10,
      MODE_FREEZE = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } chan_state_e;

   // Width needed to hold the values 0..hold_cycles without wrapping.
   function automatic int unsigned cnt_width(int unsigned hold_cycles);
      return $clog2(hold_cycles + 1);
   endfunction

endpackage

// File: rtl/dlatch_chan.sv
// One storage channel: edge detector, IDLE/HOLD FSM with window counter,
// registered data, capture pulse and busy flag.
module dlatch_chan
   import dlatch_pkg::*;
#(
   parameter int unsigned      WIDTH       = 1,
   parameter int unsigned      HOLD_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic             cap,
   output logic             busy
);

   localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES);

   chan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             cap_q, cap_d;
   logic             en_prev_q;
   logic             en_rise;
   mode_e            mode_s;

   assign mode_s  = mode_e'(mode);
   assign en_rise = en & ~en_prev_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      cap_d   = 1'b0;
      if (clr) begin
         q_d     = RESET_VAL;
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (mode_s)
            MODE_LEVEL: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (en) begin
                  q_d   = d;
                  cap_d = 1'b1;
               end
            end
            MODE_EDGE: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (en_rise) begin
                  q_d   = d;
                  cap_d = 1'b1;
               end
            end
            MODE_HOLD: begin
               if (state_q == ST_IDLE) begin
                  if (en_rise) begin
                     q_d     = d;
                     cap_d   = 1'b1;
                     cnt_d   = CNT_W'(HOLD_CYCLES);
                     state_d = ST_HOLD;
                  end
               end else begin
                  // en and d are ignored for the whole window, including the exit edge.
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = ST_IDLE;
                  end
               end
            end
            MODE_FREEZE: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         q_q       <= RESET_VAL;
         cap_q     <= 1'b0;
         en_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         cap_q     <= cap_d;
         en_prev_q <= en;
      end
   end

   assign q    = q_q;
   assign cap  = cap_q;
   assign busy = (state_q == ST_HOLD);

endmodule

// File: rtl/dlatch_bank.sv
// Bank of independent clocked capture channels sharing one global capture mode.
// Channel c occupies bits [c*WIDTH +: WIDTH] of d and q.
module dlatch_bank
   import dlatch_pkg::*;
#(
   parameter int unsigned      WIDTH       = 1,
   parameter int unsigned      CHANNELS    = 4,
   parameter int unsigned      HOLD_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [1:0]                mode,
   input  logic [CHANNELS*WIDTH-1:0] d,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       clr,
   output logic [CHANNELS*WIDTH-1:0] q,
   output logic [CHANNELS-1:0]       cap,
   output logic [CHANNELS-1:0]       busy
);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      dlatch_chan #(
         .WIDTH       (WIDTH),
         .HOLD_CYCLES (HOLD_CYCLES),
         .RESET_VAL   (RESET_VAL)
      ) u_chan (
         .clk  (clk),
         .rstn (rstn),
         .mode (mode),
         .d    (d[c*WIDTH +: WIDTH]),
         .en   (en[c]),
         .clr  (clr[c]),
         .q    (q[c*WIDTH +: WIDTH]),
         .cap  (cap[c]),
         .busy (busy[c])
      );
   end

endmodule
